im_arbiter: RTL and testbench
=============================

IM_ARBITER -- requirements
Module: im_arbiter

Interface
REQ-001 The block SHALL have parameter BASE, default 32'h0000_3000, meaning the byte address mapped to BRAM word 0.
REQ-002 The block SHALL have parameter AW, default 11, meaning the BRAM word-address width (depth 2^AW words).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous and active-high.
REQ-005 f_req  input  1  fetch read request.
REQ-006 f_addr  input  32  fetch byte address.
REQ-007 f_ready  output  1  fetch request accepted this cycle (combinational).
REQ-008 f_valid  output  1  fetch result present (registered).
REQ-009 f_instr  output  32  fetched instruction word.
REQ-010 f_err  output  1  fetch result is an address fault (registered).
REQ-011 ld_req  input  1  loader write request.
REQ-012 ld_addr  input  32  loader byte address.
REQ-013 ld_wdata  input  32  loader write data.
REQ-014 ld_ack  output  1  loader request accepted this cycle (combinational).
REQ-015 ld_err  output  1  accepted loader request faulted (combinational, qualified by ld_ack).
REQ-016 bram_we  output  4  BRAM byte write enables.
REQ-017 bram_addr  output  AW  BRAM word address.
REQ-018 bram_din  output  32  BRAM write data.
REQ-019 bram_dout  input  32  BRAM read data; 1-cycle synchronous read latency.

Function
REQ-020 Offset SHALL be addr - BASE, computed modulo 2^32; an address is legal iff offset < 2^(AW+2) unsigned and addr[1:0] == 2'b00. Addresses below BASE wrap to large offsets and are therefore illegal.
REQ-021 Each cycle the block SHALL grant at most one requester; with a single requester, that requester SHALL be granted.
REQ-022 With f_req and ld_req both high, the grant SHALL go to the requester selected by 1-bit register prio (0 = fetch, 1 = loader).
REQ-023 After any grant, prio SHALL be set to point at the requester not granted (round-robin); with no grant, prio SHALL hold.
REQ-024 A granted fetch with a legal address SHALL drive bram_addr = offset[AW+1:2] and bram_we = 4'h0 in the grant cycle, and assert f_ready.
REQ-025 A granted fetch SHALL produce f_valid = 1 exactly one cycle after the grant; f_instr SHALL equal bram_dout and f_err SHALL be 0.
REQ-026 A granted fetch with an illegal address SHALL NOT access the BRAM (bram_we = 0, bram_addr = 0); the next cycle SHALL show f_valid = 1, f_err = 1, f_instr = 32'h0.
REQ-027 Fetches SHALL pipeline back-to-back: a grant in every cycle yields f_valid in every following cycle, in request order.
REQ-028 When f_valid = 0, f_instr SHALL be 32'h0 and f_err SHALL be 0.
REQ-029 A granted legal loader write SHALL drive bram_we = 4'hF, bram_addr = offset[AW+1:2] and bram_din = ld_wdata, and assert ld_ack with ld_err = 0, all in the same cycle.
REQ-030 A granted illegal loader write SHALL assert ld_ack with ld_err = 1 and drive bram_we = 0.
REQ-031 A loader write SHALL NOT produce f_valid in the following cycle.
REQ-032 With no grant, bram_we, bram_addr and bram_din SHALL all be 0; f_ready, ld_ack and ld_err SHALL be 0.
REQ-033 A fetch to the same word as a loader write granted in the previous cycle SHALL return the new data (BRAM write-first).
REQ-034 Requesters SHALL hold req/addr/data until accepted; there is no backpressure on f_valid.

Reset
REQ-035 While reset is high: prio = 0; the pending-read flag = 0; the pending-error flag = 0; f_valid = 0; f_err = 0; f_instr = 0.
REQ-036 Reset asserted mid-fetch SHALL discard the pending result; no f_valid SHALL appear after reset deasserts until a new grant.
REQ-037 First cycle after reset: fetch SHALL win any contention.

Verification
REQ-038 Fetch f_addr = 32'h0000_3004, BRAM word 1 = 32'h2408_0001 -> f_ready cycle N, bram_addr = 1; f_valid = 1 with f_instr = 32'h2408_0001 at N+1.
REQ-039 ld_req to 32'h0000_3010 with data 32'hDEAD_BEEF, then a fetch to 32'h0000_3010 -> bram_we = 4'hF, bram_addr = 4 on the write; the fetch returns 32'hDEAD_BEEF.
REQ-040 f_req and ld_req held high for 4 cycles after reset -> grants alternate F, L, F, L; f_valid appears only after the F cycles.
REQ-041 Fetches to 32'h0000_2FFC, 32'h0000_5000 and 32'h0000_3002 -> each gives f_valid = 1, f_err = 1, f_instr = 0, and bram_we stays 0 throughout.
REQ-042 Fetches issued on 5 consecutive cycles to 32'h3000, 32'h3004, ..., 32'h3010 -> 5 consecutive f_valid cycles returning words 0-4 in order.
REQ-043 Reset pulsed in the cycle after a fetch grant -> f_valid = 0 immediately and stays 0 until the next grant.

Source files
------------

// File: rtl/im_arbiter.sv
// im_arbiter: two-requester arbiter in front of a single-port instruction BRAM.
//
// Fetch port reads one 32-bit word. The result is returned one cycle after the grant.
// Loader port writes one 32-bit word. It is acknowledged in the grant cycle.
// When both ports request in the same cycle, a 1-bit round-robin pointer picks the winner.
// Addresses outside [BASE, BASE + 4*2^AW) or not word-aligned are faults:
//   - a faulting fetch returns f_err with f_instr = 0;
//   - a faulting load returns ld_err;
//   - neither touches the BRAM.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   f_req, f_addr         fetch request / byte address
//   f_ready               fetch accepted this cycle (combinational)
//   f_valid, f_instr,     fetch result one cycle after grant (registered flags)
//   f_err
//   ld_req, ld_addr,      loader write request / byte address / data
//   ld_wdata
//   ld_ack, ld_err        loader accepted / accepted-with-fault (combinational)
//   bram_we, bram_addr,   BRAM byte enables, word address, write data
//   bram_din
//   bram_dout             BRAM read data, one-cycle synchronous latency
module im_arbiter #(
    parameter logic [31:0] BASE = 32'h0000_3000,
    parameter int unsigned AW   = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [31:0]   f_addr,
    output logic          f_ready,
    output logic          f_valid,
    output logic [31:0]   f_instr,
    output logic          f_err,
    input  logic          ld_req,
    input  logic [31:0]   ld_addr,
    input  logic [31:0]   ld_wdata,
    output logic          ld_ack,
    output logic          ld_err,
    output logic [3:0]    bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [31:0]   bram_din,
    input  logic [31:0]   bram_dout
);

    localparam int unsigned SpanBits = AW + 2;

    logic        prio_q, prio_d;      // 0: fetch wins contention, 1: loader wins
    logic        rd_pend_q, rd_pend_d;
    logic        err_pend_q, err_pend_d;

    logic [31:0] f_off, ld_off;
    logic        f_legal, ld_legal;
    logic        grant_f, grant_l;

    // Subtraction wraps, so addresses below BASE become huge offsets and fail the range test.
    assign f_off    = f_addr - BASE;
    assign ld_off   = ld_addr - BASE;
    assign f_legal  = ((f_off >> SpanBits) == 32'd0) && (f_addr[1:0] == 2'b00);
    assign ld_legal = ((ld_off >> SpanBits) == 32'd0) && (ld_addr[1:0] == 2'b00);

    always_comb begin
        grant_f = 1'b0;
        grant_l = 1'b0;
        if (f_req && ld_req) begin
            grant_f = ~prio_q;
            grant_l = prio_q;
        end else begin
            grant_f = f_req;
            grant_l = ld_req;
        end
    end

    always_comb begin
        bram_we    = 4'h0;
        bram_addr  = '0;
        bram_din   = 32'h0;
        f_ready    = grant_f;
        ld_ack     = grant_l;
        ld_err     = grant_l & ~ld_legal;
        prio_d     = prio_q;
        rd_pend_d  = grant_f & f_legal;
        err_pend_d = grant_f & ~f_legal;

        if (grant_f) begin
            prio_d = 1'b1;
            if (f_legal) begin
                bram_addr = f_off[AW+1:2];
            end
        end else if (grant_l) begin
            prio_d = 1'b0;
            if (ld_legal) begin
                bram_we   = 4'hF;
                bram_addr = ld_off[AW+1:2];
                bram_din  = ld_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q     <= 1'b0;
            rd_pend_q  <= 1'b0;
            err_pend_q <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            rd_pend_q  <= rd_pend_d;
            err_pend_q <= err_pend_d;
        end
    end

    // Result outputs decode only registered flags.
    // Read data passes straight through from the BRAM's registered output.
    assign f_valid = rd_pend_q | err_pend_q;
    assign f_err   = err_pend_q;
    assign f_instr = rd_pend_q ? bram_dout : 32'h0;

endmodule

// File: tb/tb_im_arbiter.sv
module tb_im_arbiter;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int unsigned AW    = 11;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          f_req = 1'b0;
    logic [31:0]   f_addr = 32'h0;
    logic          f_ready, f_valid, f_err;
    logic [31:0]   f_instr;
    logic          ld_req = 1'b0;
    logic [31:0]   ld_addr = 32'h0;
    logic [31:0]   ld_wdata = 32'h0;
    logic          ld_ack, ld_err;
    logic [3:0]    bram_we;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_din;
    logic [31:0]   bram_dout = 32'h0;

    int total = 0;
    int bad = 0;

    im_arbiter #(.BASE(BASE), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready),
        .f_valid(f_valid), .f_instr(f_instr), .f_err(f_err),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_err(ld_err),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout)
    );

    always #5 clk = ~clk;

    // Write-first synchronous BRAM with byte enables.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        logic [31:0] w;
        w = mem[bram_addr];
        for (int b = 0; b < 4; b++) if (bram_we[b]) w[8*b +: 8] = bram_din[8*b +: 8];
        mem[bram_addr] <= w;
        bram_dout      <= w;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents, round-robin turn, and the result owed next cycle.
    logic [31:0] ref_mem [DEPTH];
    logic        m_turn_ld = 1'b0;
    logic        m_valid = 1'b0, m_err = 1'b0;
    logic [31:0] m_instr = 32'h0;

    function automatic logic legal(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off < 32'(DEPTH * 4)) && (a % 4 == 0);
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a - BASE) / 4;
    endfunction

    always @(negedge clk) begin
        logic        gf, gl, lf, ll;
        logic [3:0]  e_we;
        logic [31:0] e_addr, e_din;
        if (reset) begin
            m_turn_ld = 1'b0;
            m_valid   = 1'b0;
            m_err     = 1'b0;
            m_instr   = 32'h0;
        end
        chk("f_valid", {31'b0, f_valid}, {31'b0, m_valid});
        chk("f_err", {31'b0, f_err}, {31'b0, m_err});
        chk("f_instr", f_instr, m_instr);
        if (!reset) begin
            if (f_req && ld_req) begin
                gf = !m_turn_ld;
                gl = m_turn_ld;
            end else begin
                gf = f_req;
                gl = ld_req;
            end
            lf = legal(f_addr);
            ll = legal(ld_addr);
            e_we = 4'h0; e_addr = 32'h0; e_din = 32'h0;
            if (gf && lf) e_addr = word_of(f_addr);
            if (gl && ll) begin
                e_we = 4'hF; e_addr = word_of(ld_addr); e_din = ld_wdata;
            end
            chk("f_ready", {31'b0, f_ready}, {31'b0, gf});
            chk("ld_ack", {31'b0, ld_ack}, {31'b0, gl});
            chk("ld_err", {31'b0, ld_err}, {31'b0, gl && !ll});
            chk("bram_we", {28'b0, bram_we}, {28'b0, e_we});
            chk("bram_addr", {{(32-AW){1'b0}}, bram_addr}, e_addr);
            chk("bram_din", bram_din, e_din);
            if (gl && ll) ref_mem[word_of(ld_addr)] = ld_wdata;
            m_valid = gf;
            m_err   = gf && !lf;
            m_instr = (gf && lf) ? ref_mem[word_of(f_addr)] : 32'h0;
            if (gf) m_turn_ld = 1'b1;
            else if (gl) m_turn_ld = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        f_req = 1'b0;
        ld_req = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 19);
        case (r)
            0: return BASE - 32'(4 * (1 + $urandom_range(0, 3)));
            1: return BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 3));
            2: return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            3: return BASE + 32'(DEPTH * 4 - 4);
            4: return 32'hFFFF_FFFC;
            default: return BASE + 32'(4 * $urandom_range(0, 15));
        endcase
    endfunction

    logic [31:0] bad_addrs [3];
    logic        fa, la;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]     = 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
            ref_mem[i] = 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
        end
        mem[1]     = 32'h2408_0001;
        ref_mem[1] = 32'h2408_0001;

        do_reset();

        // Single legal fetch of word 1.
        f_req = 1'b1; f_addr = 32'h0000_3004;
        @(negedge clk);
        chk("p38_ready", {31'b0, f_ready}, 32'h1);
        chk("p38_addr", {{(32-AW){1'b0}}, bram_addr}, 32'h1);
        step();
        f_req = 1'b0;
        @(negedge clk);
        chk("p38_valid", {31'b0, f_valid}, 32'h1);
        chk("p38_instr", f_instr, 32'h2408_0001);
        step();

        // Write then read back the same word.
        ld_req = 1'b1; ld_addr = 32'h0000_3010; ld_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("p39_we", {28'b0, bram_we}, 32'hF);
        chk("p39_addr", {{(32-AW){1'b0}}, bram_addr}, 32'h4);
        chk("p39_ack", {31'b0, ld_ack}, 32'h1);
        step();
        ld_req = 1'b0; f_req = 1'b1; f_addr = 32'h0000_3010;
        @(negedge clk);
        chk("p39_nofv", {31'b0, f_valid}, 32'h0);
        step();
        f_req = 1'b0;
        @(negedge clk);
        chk("p39_instr", f_instr, 32'hDEAD_BEEF);
        step();

        // Contention straight after reset alternates F, L, F, L.
        do_reset();
        f_req = 1'b1; f_addr = 32'h0000_3000;
        ld_req = 1'b1; ld_addr = 32'h0000_3020; ld_wdata = 32'h1111_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("p40_fready", {31'b0, f_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("p40_ldack", {31'b0, ld_ack}, (i % 2 == 1) ? 32'h1 : 32'h0);
            chk("p40_fvalid", {31'b0, f_valid}, (i % 2 == 1) ? 32'h1 : 32'h0);
            step();
        end
        f_req = 1'b0; ld_req = 1'b0;
        step();

        // Faulting fetches.
        bad_addrs[0] = 32'h0000_2FFC;
        bad_addrs[1] = 32'h0000_5000;
        bad_addrs[2] = 32'h0000_3002;
        for (int i = 0; i < 3; i++) begin
            f_req = 1'b1; f_addr = bad_addrs[i];
            @(negedge clk);
            chk("p41_ready", {31'b0, f_ready}, 32'h1);
            chk("p41_we", {28'b0, bram_we}, 32'h0);
            step();
            f_req = 1'b0;
            @(negedge clk);
            chk("p41_valid", {31'b0, f_valid}, 32'h1);
            chk("p41_err", {31'b0, f_err}, 32'h1);
            chk("p41_instr", f_instr, 32'h0);
            step();
        end

        // Back-to-back fetches of words 0..4.
        for (int i = 0; i < 5; i++) begin
            f_req = 1'b1; f_addr = BASE + 32'(4 * i);
            @(negedge clk);
            if (i > 0) chk("p42_valid", {31'b0, f_valid}, 32'h1);
            step();
        end
        f_req = 1'b0;
        @(negedge clk);
        chk("p42_last", f_instr, ref_mem[4]);
        step();

        // Reset in the cycle after a fetch grant drops the result.
        f_req = 1'b1; f_addr = 32'h0000_3008;
        step();
        f_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("p43_valid_rst", {31'b0, f_valid}, 32'h0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("p43_valid_after", {31'b0, f_valid}, 32'h0);
            step();
        end

        // Randomized traffic; requesters hold until accepted.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            fa = f_ready;
            la = ld_ack;
            step();
            if (!f_req || fa) begin
                f_req = ($urandom_range(0, 3) != 0);
                f_addr = rand_addr();
            end
            if (!ld_req || la) begin
                ld_req = ($urandom_range(0, 2) == 0);
                ld_addr = rand_addr();
                ld_wdata = $urandom;
            end
        end
        f_req = 1'b0; ld_req = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
